// File: rtl/sram_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1rw_arbiter
//  Description : Two-requester round-robin front end for a single-port 1RW
//                SRAM macro (active-low CSb/WEb/OEb, shared tri-state DATA).
//                Optional grant counters enabled by SRAM_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_grants0,
    output logic [15:0]           stat_grants1
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ_A = 3'd2,
        ST_READ_B = 3'd3,
        ST_TURN   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_last_grant;
    logic                    r_rd_id;
    logic [ADDR_WIDTH-1:0]   r_hold_addr;
    logic [DATA_WIDTH-1:0]   r_hold_wdata;

    logic                    r_csb;
    logic                    r_web;
    logic                    r_oeb;
    logic                    r_drive;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;

    logic                    w_csb_nxt;
    logic                    w_web_nxt;
    logic                    w_oeb_nxt;
    logic                    w_drive_nxt;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_wdata_nxt;

    logic                    r_rsp_valid;
    logic                    r_rsp_id;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic                    w_grantable;
    logic                    w_pick0;
    logic                    w_pick1;
    logic                    w_accept;
    logic                    w_acc_id;
    logic                    w_acc_we;
    logic [ADDR_WIDTH-1:0]   w_acc_addr;
    logic [DATA_WIDTH-1:0]   w_acc_wdata;

    // ------------------------------------------------------------------
    // Round-robin selection: on contention the side not granted last wins.
    // ------------------------------------------------------------------
    assign w_grantable = (r_state == ST_IDLE) || (r_state == ST_WRITE) ||
                         (r_state == ST_READ_B);
    assign w_pick0     = req0_valid && (!req1_valid ||  r_last_grant);
    assign w_pick1     = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready  = w_grantable && w_pick0;
    assign req1_ready  = w_grantable && w_pick1;

    assign w_accept    = req0_ready || req1_ready;
    assign w_acc_id    = req1_ready;
    assign w_acc_we    = w_acc_id ? req1_we    : req0_we;
    assign w_acc_addr  = w_acc_id ? req1_addr  : req0_addr;
    assign w_acc_wdata = w_acc_id ? req1_wdata : req0_wdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (w_accept) begin
                    w_state_nxt = w_acc_we ? ST_WRITE : ST_READ_A;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ_A: w_state_nxt = ST_READ_B;
            ST_READ_B: begin
                // A write straight after a read needs a dead cycle so the
                // macro releases DATA before this block drives it.
                if (w_accept) begin
                    w_state_nxt = w_acc_we ? ST_TURN : ST_READ_A;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TURN:   w_state_nxt = ST_WRITE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_csb_nxt   = 1'b1;
        w_web_nxt   = 1'b1;
        w_oeb_nxt   = 1'b1;
        w_drive_nxt = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (w_state_nxt)
            ST_WRITE: begin
                w_csb_nxt   = 1'b0;
                w_web_nxt   = 1'b0;
                w_drive_nxt = 1'b1;
                if (r_state == ST_TURN) begin
                    w_addr_nxt  = r_hold_addr;
                    w_wdata_nxt = r_hold_wdata;
                end else begin
                    w_addr_nxt  = w_acc_addr;
                    w_wdata_nxt = w_acc_wdata;
                end
            end
            ST_READ_A: begin
                w_csb_nxt  = 1'b0;
                w_oeb_nxt  = 1'b0;
                w_addr_nxt = w_acc_addr;
            end
            ST_READ_B: begin
                w_csb_nxt   = r_csb;
                w_web_nxt   = r_web;
                w_oeb_nxt   = r_oeb;
                w_drive_nxt = r_drive;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_rd_id      <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
            r_csb        <= 1'b1;
            r_web        <= 1'b1;
            r_oeb        <= 1'b1;
            r_drive      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_csb   <= w_csb_nxt;
            r_web   <= w_web_nxt;
            r_oeb   <= w_oeb_nxt;
            r_drive <= w_drive_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_accept) begin
                r_last_grant <= w_acc_id;
            end
            if (w_state_nxt == ST_READ_A) begin
                r_rd_id <= w_acc_id;
            end
            if (w_state_nxt == ST_TURN) begin
                r_hold_addr  <= w_acc_addr;
                r_hold_wdata <= w_acc_wdata;
            end
        end
    end

    // Read data is on the bus during READ_B; capture it as that cycle ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= (r_state == ST_READ_B);
            if (r_state == ST_READ_B) begin
                r_rsp_id    <= r_rd_id;
                r_rsp_rdata <= sram_data;
            end
        end
    end

    assign sram_csb  = r_csb;
    assign sram_web  = r_web;
    assign sram_oeb  = r_oeb;
    assign sram_addr = r_addr;
    assign sram_data = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;

`ifdef SRAM_ARB_STATS_EN
    localparam logic [15:0] c_stat_max = 16'hFFFF;

    logic [15:0] r_stat0;
    logic [15:0] r_stat1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat0 <= '0;
            r_stat1 <= '0;
        end else begin
            if (req0_ready && (r_stat0 != c_stat_max)) begin
                r_stat0 <= r_stat0 + 16'd1;
            end
            if (req1_ready && (r_stat1 != c_stat_max)) begin
                r_stat1 <= r_stat1 + 16'd1;
            end
        end
    end

    assign stat_grants0 = r_stat0;
    assign stat_grants1 = r_stat1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_1rw_arbiter
//  Description : Randomized bench for sram_1rw_arbiter with an SRAM macro
//                model and a transaction-level scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1rw_arbiter;

    localparam int DW       = 128;
    localparam int AW       = 10;
    localparam int DEPTH    = 1 << AW;
    localparam int N_CYCLES = 4000;

    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int K_TURN = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic          req0_we, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          rsp_valid, rsp_id;
    logic [DW-1:0] rsp_rdata;
    logic          sram_csb, sram_web, sram_oeb;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0]   stat_grants0, stat_grants1;
`endif

    sram_1rw_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_oeb   (sram_oeb),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data)
`ifdef SRAM_ARB_STATS_EN
        ,
        .stat_grants0 (stat_grants0),
        .stat_grants1 (stat_grants1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] preload(input int i);
        preload = {4{32'(i) ^ 32'h5A5A_0000}};
    endfunction

    // Behavioural 1RW macro: samples pins at the edge, drives DATA while OEb low.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_dout;
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] <= preload(i);
        sram_dout <= '0;
    end
    always @(posedge clk) begin
        if (!sram_csb && !sram_web)  sram_mem[sram_addr] <= sram_data;
        else if (!sram_csb)          sram_dout <= sram_mem[sram_addr];
    end
    assign sram_data = (sram_oeb == 1'b0) ? sram_dout : {DW{1'bz}};

    // Scoreboard: memory image, expected responses and a per-cycle pin schedule.
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    rsp_t          rq[$];
    int            pk[int];
    logic [AW-1:0] pa[int];
    logic [DW-1:0] pd[int];
    logic          pw_valid;
    int            pw_edge;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;
    int            cyc, next_ok, last_rd, rst_edge;
    logic          last_grant;
    logic          grant_ok, p0, p1, acc0, acc1;
    int            n_grant0, n_grant1;
    int            vectors, errors;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        int k;
        if (rst_edge == cyc) begin
            check_eq("rst_addr",  sram_addr, '0);
            check_eq("rst_rspid", rsp_id,    '0);
            check_eq("rst_rdata", rsp_rdata, '0);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check_eq("rsp_valid", rsp_valid, 1'b1);
            check_eq("rsp_id",    rsp_id,    rq[0].id);
            check_eq("rsp_rdata", rsp_rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check_eq("rsp_idle", rsp_valid, 1'b0);
        end
        k = pk.exists(cyc) ? pk[cyc] : K_IDLE;
        case (k)
            K_WR: begin
                check_eq("wr_csb",  sram_csb,  1'b0);
                check_eq("wr_web",  sram_web,  1'b0);
                check_eq("wr_oeb",  sram_oeb,  1'b1);
                check_eq("wr_addr", sram_addr, pa[cyc]);
                check_eq("wr_data", sram_data, pd[cyc]);
            end
            K_RD: begin
                check_eq("rd_csb",  sram_csb,  1'b0);
                check_eq("rd_web",  sram_web,  1'b1);
                check_eq("rd_oeb",  sram_oeb,  1'b0);
                check_eq("rd_addr", sram_addr, pa[cyc]);
                check_eq("rd_bus_x", $isunknown(sram_data), 1'b0);
            end
            default: begin
                check_eq(k == K_TURN ? "turn_csb" : "idle_csb", sram_csb, 1'b1);
                check_eq("idle_web", sram_web, 1'b1);
                check_eq("idle_oeb", sram_oeb, 1'b1);
                check_eq(k == K_TURN ? "turn_bus" : "idle_bus", sram_data, {DW{1'bz}});
            end
        endcase
        if (pk.exists(cyc)) begin
            pk.delete(cyc);
            pa.delete(cyc);
            pd.delete(cyc);
        end
    endtask

    // Transaction-level effect of one clock edge.
    task automatic model_edge(input logic r, input logic acc, input logic sel);
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        if (pw_valid && pw_edge == cyc) begin
            ref_mem[pw_addr] = pw_data;
            pw_valid = 1'b0;
        end
        if (r) begin
            pw_valid   = 1'b0;
            rq.delete();
            pk.delete();
            pa.delete();
            pd.delete();
            last_grant = 1'b1;
            next_ok    = cyc + 1;
            last_rd    = -100;
            rst_edge   = cyc;
            n_grant0   = 0;
            n_grant1   = 0;
        end else if (acc) begin
            we   = sel ? req1_we    : req0_we;
            addr = sel ? req1_addr  : req0_addr;
            data = sel ? req1_wdata : req0_wdata;
            last_grant = sel;
            if (sel) n_grant1++; else n_grant0++;
            if (we) begin
                if (last_rd == cyc - 2) begin
                    pk[cyc]     = K_TURN;
                    pk[cyc + 1] = K_WR;
                    pa[cyc + 1] = addr;
                    pd[cyc + 1] = data;
                    pw_edge     = cyc + 2;
                    next_ok     = cyc + 2;
                end else begin
                    pk[cyc] = K_WR;
                    pa[cyc] = addr;
                    pd[cyc] = data;
                    pw_edge = cyc + 1;
                    next_ok = cyc + 1;
                end
                pw_valid = 1'b1;
                pw_addr  = addr;
                pw_data  = data;
            end else begin
                pk[cyc]     = K_RD;
                pk[cyc + 1] = K_RD;
                pa[cyc]     = addr;
                pa[cyc + 1] = addr;
                rq.push_back('{due: cyc + 2, id: sel, data: ref_mem[addr]});
                next_ok = cyc + 2;
                last_rd = cyc;
            end
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)       rand_addr = AW'($urandom_range(0, 15));
        else if (r == 6) rand_addr = {AW{1'b1}};
        else             rand_addr = AW'($urandom);
    endfunction

    initial begin
        vectors = 0;
        errors  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);
        cyc = 0; next_ok = 0; last_rd = -100; rst_edge = -1;
        last_grant = 1'b1; pw_valid = 1'b0; pw_edge = 0;
        pw_addr = '0; pw_data = '0;
        n_grant0 = 0; n_grant1 = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        for (int n = 0; n < N_CYCLES; n++) begin
            @(negedge clk);
            grant_ok = (cyc + 1 >= next_ok);
            p0 = req0_valid && (!req1_valid ||  last_grant);
            p1 = req1_valid && (!req0_valid || !last_grant);
            if (cyc > 0) begin
                check_cycle();
                check_eq("ready0", req0_ready, grant_ok && p0);
                check_eq("ready1", req1_ready, grant_ok && p1);
            end
            @(posedge clk);
            cyc++;
            acc0 = !rst && grant_ok && p0;
            acc1 = !rst && grant_ok && p1;
            model_edge(rst, acc0 || acc1, p1);
            #1;
            rst = (n < 1) || (n > 4 && $urandom_range(0, 79) == 0);
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = rand_addr();
                req0_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = rand_addr();
                req1_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end

`ifdef SRAM_ARB_STATS_EN
        @(negedge clk);
        check_eq("stat0", stat_grants0, 16'(n_grant0 > 65535 ? 65535 : n_grant0));
        check_eq("stat1", stat_grants1, 16'(n_grant1 > 65535 ? 65535 : n_grant1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_1rw_arbiter.md
Name: sram_1rw_arbiter

Overview:
- Two-requester round-robin controller for one single-port 1RW OpenRAM macro with active-low CSb/WEb/OEb and a shared tri-state DATA bus.
- Accepts read/write commands over valid/ready and sequences the SRAM pins, including read capture and bus turnaround.
- Returns read data tagged with the requester id.
- Sits between datapath clients and the SRAM macro instance.

Parameters:
- DATA_WIDTH, 128, word width; matches the macro.
- ADDR_WIDTH, 10, address width; depth is 1<<ADDR_WIDTH.

Ports:
- clk  in  1  clock; SRAM macro uses the same clk.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  command valid, requester 0 / 1.
- req0_ready / req1_ready  out  1  command accepted this cycle.
- req0_we / req1_we  in  1  1=write, 0=read.
- req0_addr / req1_addr  in  ADDR_WIDTH  word address.
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_id  out  1  requester that issued the read.
- rsp_rdata  out  DATA_WIDTH  read data.
- sram_csb  out  1  to macro CSb.
- sram_web  out  1  to macro WEb.
- sram_oeb  out  1  to macro OEb.
- sram_addr  out  ADDR_WIDTH  to macro ADDR.
- sram_data  inout  DATA_WIDTH  to macro DATA; driven only in WRITE, else high-Z.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high; an edge with rst=1 takes priority over everything below.
- Outputs on reset: state=IDLE; sram_csb=sram_web=sram_oeb=1; sram_addr=0; sram_data released; rsp_valid=0, rsp_id=0, rsp_rdata=0; last_grant=1, so requester 0 wins first.
- Registered outputs: all SRAM pins and rsp_* are registered.
- Combinational ready: reqN_ready = grantable state AND arbiter selects N. Grantable states are IDLE, WRITE and READ_B.
- Arbitration: if only one valid, grant it. If both valid, grant the requester that is not last_grant. last_grant updates on every accept.
- FSM, accept at edge E:
  - Write → WRITE: csb=0, web=0, oeb=1, sram_data driven with wdata. The macro writes at E+1. Writes can run back-to-back, one per cycle.
  - Read → READ_A: csb=0, web=1, oeb=0. The macro samples the address at E+1.
  - READ_A → READ_B: pins unchanged, so DATA stays enabled.
  - READ_B capture: sram_data is captured at E+2. rsp_valid=1, rsp_id and rsp_rdata are set for the cycle after E+2.
  - Read latency: accept edge to rsp_valid high is 2 cycles. Read throughput is one per 2 cycles.
- READ_B next state:
  - New read accepted → READ_A.
  - New write accepted → TURN, holding the command. TURN: csb=oeb=web=1, bus released, ready=0. TURN then → WRITE with the held command. Write-after-read costs 1 extra cycle.
  - Nothing accepted → IDLE.
- WRITE → READ_A directly; no turnaround needed.
- IDLE: pins deasserted.
- Read-after-write, same address, back-to-back: must return the new data, since the macro writes at E+1 before sampling the read at E+2.
- No queueing: a valid that is not granted must be held stable by the requester.
- rst mid-read: the in-flight read is dropped, with no rsp_valid. rst during TURN discards the held write.
- ADDR_WIDTH arithmetic: no wrap logic, the address passes through unchanged.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined: adds outputs stat_grants0 and stat_grants1, 16 bits each. Each increments on that requester's accept and saturates at 16'hFFFF. Both clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single write then read: req0 writes addr 10'h005, data 128'hA5A5…A5. req0 then reads 10'h005 → rsp_valid exactly 2 cycles after the read accept, rsp_id=0, rsp_rdata=128'hA5A5…A5.
- Contention: req0 and req1 both hold reads of addr 1 and 2 (preloaded 1 and 2) → grants alternate 0,1,0,1. rsp sequence is (id0,1), (id1,2). Neither requester starves.
- Write-after-read turnaround: read 10'h3FF, then a write is immediately pending → one TURN cycle with csb=1 and sram_data high-Z, then WRITE. No X on sram_data at any clock edge.
- Back-to-back writes: 4 writes at addrs 0–3 with data 0x11–0x44 → 4 consecutive accepts. Readback returns 0x11, 0x22, 0x33, 0x44.
- Reset mid-read: rst in READ_A → no rsp_valid; all pins 1 next cycle. The next request is granted to req0.
- With SRAM_ARB_STATS_EN: 3 req0 and 5 req1 accepts → stat_grants0=3, stat_grants1=5. rst → both read 0.
